// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: branch-mask types, FU result and
// branch-stack resolution packets.
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

package branch_resolve_queue_pkg;

  typedef logic [31:0]              ADDR;
  typedef logic [`B_MASK_WIDTH-1:0] B_MASK;
  typedef logic [`B_MASK_WIDTH-1:0] B_MASK_MASK;

  // Resolution handed to the branch stack; bmm == 0 means "nothing this cycle".
  typedef struct packed {
    B_MASK_MASK bmm;
    logic       bm_mispred;
    ADDR        target_PC;
    logic       taken;
  } BRANCH_REG_PACKET;

  typedef struct packed {
    B_MASK_MASK bmm;
    B_MASK      b_m;
    logic       taken;
    logic       pred_taken;
    ADDR        target_PC;
  } BR_RESULT_PACKET;

  typedef struct packed {
    logic  valid;
    B_MASK b_m;
    logic  mispred;
    logic  pred_taken;
    ADDR   target_PC;
  } brq_slot_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Bundle between the branch FUs / branch stack and the branch resolve queue.
interface branch_resolve_queue_if
  import branch_resolve_queue_pkg::*;
#(
  parameter int NUM_BR_FU = 2
);
  logic [NUM_BR_FU-1:0]                        fu_br_valid;
  logic [NUM_BR_FU-1:0][`B_MASK_WIDTH-1:0]     fu_br_bmm;
  logic [NUM_BR_FU-1:0][`B_MASK_WIDTH-1:0]     fu_br_b_m;
  logic [NUM_BR_FU-1:0]                        fu_br_taken;
  logic [NUM_BR_FU-1:0]                        fu_br_pred_taken;
  logic [NUM_BR_FU-1:0][31:0]                  fu_br_target_PC;
  BRANCH_REG_PACKET                            branch_completing;
  logic [`B_MASK_WIDTH-1:0]                    pending_mask;

  modport master (
    output fu_br_valid, fu_br_bmm, fu_br_b_m, fu_br_taken, fu_br_pred_taken,
           fu_br_target_PC,
    input  branch_completing, pending_mask
  );

  modport slave (
    input  fu_br_valid, fu_br_bmm, fu_br_b_m, fu_br_taken, fu_br_pred_taken,
           fu_br_target_PC,
    output branch_completing, pending_mask
  );
endinterface

// File: rtl/brq_oldest_select.sv
// Age-ordered picker: oldest mispredict if any exists, else lowest-index valid
// entry. Age comes from each entry's dependency mask, so it is reusable by the LSQ.
module brq_oldest_select #(
  parameter int N = `B_MASK_WIDTH
) (
  input  logic [N-1:0]        valid,
  input  logic [N-1:0]        mispred,
  input  logic [N-1:0][N-1:0] b_m,
  output logic [N-1:0]        grant,
  output logic                grant_mispred
);

  logic [N-1:0] pend;

  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    pend          = valid & mispred;
    grant         = '0;
    grant_mispred = 1'b0;
    if (|pend) begin
      // The oldest mispredict depends on no other pending mispredict.
      for (int k = 0; k < N; k++) begin
        if (grant == '0 && pend[k] && (b_m[k] & pend) == '0) begin
          grant[k]      = 1'b1;
          grant_mispred = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (grant == '0 && valid[k]) grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Collects executed branch results into per-mask-bit slots and hands the branch
// stack one resolution per cycle, mispredicts first, squashing younger work.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int NUM_BR_FU = 2,
  parameter int NUM_SLOTS = `B_MASK_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  branch_resolve_queue_if.slave  brq
);

  brq_slot_t                         slot_q [NUM_SLOTS];
  brq_slot_t                         slot_d [NUM_SLOTS];
  BRANCH_REG_PACKET                  completing_q;
  BRANCH_REG_PACKET                  issue_pkt;

  logic [NUM_SLOTS-1:0]              slot_valid;
  logic [NUM_SLOTS-1:0]              slot_mispred;
  logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] slot_b_m;
  logic [NUM_SLOTS-1:0]              issue_grant;
  logic                              issue_mispred;
  logic [NUM_BR_FU-1:0]              fu_keep;
  logic                              overwrite_err;
  logic                              dup_bmm_err;

  always_comb begin
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_valid[k]   = slot_q[k].valid;
      slot_mispred[k] = slot_q[k].mispred;
      slot_b_m[k]     = slot_q[k].b_m;
    end
  end

  brq_oldest_select #(.N(NUM_SLOTS)) u_select (
    .valid         (slot_valid),
    .mispred       (slot_mispred),
    .b_m           (slot_b_m),
    .grant         (issue_grant),
    .grant_mispred (issue_mispred)
  );

  // Incoming results that depend on the branch mispredicting this cycle are dropped.
  always_comb begin
    for (int f = 0; f < NUM_BR_FU; f++) begin
      fu_keep[f] = brq.fu_br_valid[f] &&
                   !(issue_mispred && |(brq.fu_br_b_m[f] & issue_grant));
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_d[k] = slot_q[k];
      if (issue_grant[k]) slot_d[k].valid = 1'b0;
      if (issue_mispred && |(slot_q[k].b_m & issue_grant)) slot_d[k].valid = 1'b0;
      slot_d[k].b_m = slot_q[k].b_m & ~issue_grant;
      for (int f = 0; f < NUM_BR_FU; f++) begin
        if (fu_keep[f] && brq.fu_br_bmm[f][k]) begin
          slot_d[k].valid      = 1'b1;
          slot_d[k].b_m        = brq.fu_br_b_m[f] & ~issue_grant;
          slot_d[k].mispred    = brq.fu_br_taken[f] ^ brq.fu_br_pred_taken[f];
          slot_d[k].pred_taken = brq.fu_br_pred_taken[f];
          slot_d[k].target_PC  = brq.fu_br_target_PC[f];
        end
      end
    end
  end

  always_comb begin
    issue_pkt = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (issue_grant[k]) begin
        issue_pkt.bmm        = issue_grant;
        issue_pkt.bm_mispred = issue_mispred;
        issue_pkt.target_PC  = slot_q[k].target_PC;
        issue_pkt.taken      = slot_q[k].pred_taken;
      end
    end
  end

  // NOTE: the slot array is only NUM_SLOTS entries and holds valid bits, so it is
  // reset whole rather than treated as an unreset memory.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_SLOTS; k++) slot_q[k] <= '0;
      completing_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments only.
      for (int k = 0; k < NUM_SLOTS; k++) slot_q[k] <= slot_d[k];
      completing_q <= issue_pkt;
    end
  end

  assign brq.branch_completing = completing_q;
  assign brq.pending_mask      = slot_valid;

  always_comb begin
    overwrite_err = 1'b0;
    dup_bmm_err   = 1'b0;
    for (int f = 0; f < NUM_BR_FU; f++) begin
      if (brq.fu_br_valid[f] && |(brq.fu_br_bmm[f] & slot_valid & ~issue_grant))
        overwrite_err = 1'b1;
      for (int g = f + 1; g < NUM_BR_FU; g++) begin
        if (brq.fu_br_valid[f] && brq.fu_br_valid[g] &&
            |(brq.fu_br_bmm[f] & brq.fu_br_bmm[g]))
          dup_bmm_err = 1'b1;
      end
    end
  end

  a_no_overwrite: assert property (@(posedge clock) disable iff (!reset) !overwrite_err);
  a_no_dup_bmm:   assert property (@(posedge clock) disable iff (!reset) !dup_bmm_err);

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with hand-computed expected values.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  logic clock;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  branch_resolve_queue_if #(.NUM_BR_FU(2)) brq_bus ();

  branch_resolve_queue #(.NUM_BR_FU(2), .NUM_SLOTS(`B_MASK_WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .brq   (brq_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic BRANCH_REG_PACKET pkt(input logic [3:0] bmm, input logic mis,
                                           input logic [31:0] tgt, input logic tk);
    BRANCH_REG_PACKET p;
    p.bmm        = bmm;
    p.bm_mispred = mis;
    p.target_PC  = tgt;
    p.taken      = tk;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_fu();
    brq_bus.fu_br_valid      = '0;
    brq_bus.fu_br_bmm        = '0;
    brq_bus.fu_br_b_m        = '0;
    brq_bus.fu_br_taken      = '0;
    brq_bus.fu_br_pred_taken = '0;
    brq_bus.fu_br_target_PC  = '0;
  endtask

  task automatic drive_fu(input int f, input logic [3:0] bmm, input logic [3:0] b_m,
                          input logic taken, input logic pred, input logic [31:0] tgt);
    brq_bus.fu_br_valid[f]      = 1'b1;
    brq_bus.fu_br_bmm[f]        = bmm;
    brq_bus.fu_br_b_m[f]        = b_m;
    brq_bus.fu_br_taken[f]      = taken;
    brq_bus.fu_br_pred_taken[f] = pred;
    brq_bus.fu_br_target_PC[f]  = tgt;
  endtask

  initial begin
    reset = 1'b0;
    clear_fu();
    repeat (2) @(negedge clock);
    check("reset_completing", brq_bus.branch_completing, '0);
    check("reset_pending", brq_bus.pending_mask, 4'b0000);
    reset = 1'b1;
    tick();

    // Single correct branch: visible two edges after the FU cycle.
    drive_fu(0, 4'b0001, 4'b0000, 1'b1, 1'b1, 32'h100);
    tick();
    clear_fu();
    check("t1_pending_after_capture", brq_bus.pending_mask, 4'b0001);
    check("t1_no_bypass", brq_bus.branch_completing.bmm, 4'b0000);
    tick();
    check("t1_issue", brq_bus.branch_completing, pkt(4'b0001, 1'b0, 32'h100, 1'b1));
    check("t1_pending_empty", brq_bus.pending_mask, 4'b0000);
    tick();
    check("t1_idle", brq_bus.branch_completing.bmm, 4'b0000);

    // Two mispredicts together: bit0 is oldest, bit1 depends on it and is squashed.
    drive_fu(0, 4'b0010, 4'b0001, 1'b1, 1'b0, 32'h210);
    drive_fu(1, 4'b0001, 4'b0000, 1'b0, 1'b1, 32'h220);
    tick();
    clear_fu();
    check("t2_pending", brq_bus.pending_mask, 4'b0011);
    tick();
    check("t2_issue_oldest", brq_bus.branch_completing, pkt(4'b0001, 1'b1, 32'h220, 1'b1));
    check("t2_squashed", brq_bus.pending_mask, 4'b0000);
    tick();
    check("t2_bit1_never", brq_bus.branch_completing.bmm, 4'b0000);
    tick();
    check("t2_bit1_never_2", brq_bus.branch_completing.bmm, 4'b0000);

    // Correct then dependent: resolving bit0 strips it from slot 1's mask.
    drive_fu(0, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'h200);
    drive_fu(1, 4'b0010, 4'b0001, 1'b1, 1'b1, 32'h300);
    tick();
    clear_fu();
    tick();
    check("t3_first", brq_bus.branch_completing, pkt(4'b0001, 1'b0, 32'h200, 1'b0));
    check("t3_slot1_bm", dut.slot_q[1].b_m, 4'b0000);
    check("t3_pending", brq_bus.pending_mask, 4'b0010);
    tick();
    check("t3_second", brq_bus.branch_completing, pkt(4'b0010, 1'b0, 32'h300, 1'b1));
    tick();
    check("t3_idle", brq_bus.branch_completing.bmm, 4'b0000);

    // Mispredict with a same-cycle younger incoming result: the result is dropped.
    drive_fu(0, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h400);
    tick();
    clear_fu();
    drive_fu(1, 4'b0100, 4'b0001, 1'b1, 1'b1, 32'h410);
    tick();
    clear_fu();
    check("t4_issue", brq_bus.branch_completing, pkt(4'b0001, 1'b1, 32'h400, 1'b0));
    check("t4_dropped", brq_bus.pending_mask, 4'b0000);
    tick();
    check("t4_idle", brq_bus.branch_completing.bmm, 4'b0000);
    check("t4_pending", brq_bus.pending_mask, 4'b0000);

    // Mispredict beats a lower-index correct branch that is not younger.
    drive_fu(0, 4'b0100, 4'b0000, 1'b1, 1'b1, 32'h500);
    drive_fu(1, 4'b1000, 4'b0000, 1'b0, 1'b1, 32'h600);
    tick();
    clear_fu();
    check("t5_pending", brq_bus.pending_mask, 4'b1100);
    tick();
    check("t5_mispred_first", brq_bus.branch_completing, pkt(4'b1000, 1'b1, 32'h600, 1'b1));
    check("t5_slot2_kept", brq_bus.pending_mask, 4'b0100);
    tick();
    check("t5_correct_next", brq_bus.branch_completing, pkt(4'b0100, 1'b0, 32'h500, 1'b1));
    tick();
    check("t5_idle", brq_bus.branch_completing.bmm, 4'b0000);

    // Asynchronous reset with three slots pending.
    drive_fu(0, 4'b0001, 4'b0000, 1'b1, 1'b1, 32'h700);
    drive_fu(1, 4'b0010, 4'b0001, 1'b1, 1'b1, 32'h710);
    tick();
    clear_fu();
    drive_fu(0, 4'b0100, 4'b0011, 1'b0, 1'b0, 32'h720);
    drive_fu(1, 4'b1000, 4'b0011, 1'b0, 1'b0, 32'h730);
    tick();
    clear_fu();
    check("t6_pre_pending", brq_bus.pending_mask, 4'b1110);
    check("t6_pre_issue", brq_bus.branch_completing.bmm, 4'b0001);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_completing", brq_bus.branch_completing, '0);
    check("t6_async_pending", brq_bus.pending_mask, 4'b0000);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick();
    tick();
    check("t6_post_completing", brq_bus.branch_completing, '0);
    check("t6_post_pending", brq_bus.pending_mask, 4'b0000);
    drive_fu(1, 4'b0100, 4'b0000, 1'b1, 1'b1, 32'h800);
    tick();
    clear_fu();
    tick();
    check("t6_new_issue", brq_bus.branch_completing, pkt(4'b0100, 1'b0, 32'h800, 1'b1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits between the branch functional units and the branch stack.
- Collects executed branch results, up to NUM_BR_FU per cycle, and stores them in slots indexed by each branch's own B_MASK bit.
- Drives the branch stack's resolution input (BRANCH_REG_PACKET) with at most one resolution per cycle. Mispredicts go first, oldest first.
- Squashes queued results that are younger than an issued mispredict, and strips resolved bits from the dependency masks of stored results.

Parameters:
- NUM_BR_FU, 2, branch results accepted per cycle.
- NUM_SLOTS, `B_MASK_WIDTH, one slot per branch-mask bit. Must equal `B_MASK_WIDTH.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- fu_br_valid  in  NUM_BR_FU  result valid per FU
- fu_br_bmm  in  NUM_BR_FU x `B_MASK_WIDTH  one-hot own branch bit (B_MASK_MASK)
- fu_br_b_m  in  NUM_BR_FU x `B_MASK_WIDTH  masks of older unresolved branches (B_MASK)
- fu_br_taken  in  NUM_BR_FU  actual direction
- fu_br_pred_taken  in  NUM_BR_FU  predicted direction
- fu_br_target_PC  in  NUM_BR_FU x ADDR  computed taken target
- branch_completing  out  BRANCH_REG_PACKET  registered resolution {bmm, bm_mispred, target_PC, taken} to the branch stack
- pending_mask  out  `B_MASK_WIDTH  valid bits of occupied slots

Behaviour:
- Slot k fields: valid, b_m, mispred, pred_taken, target_PC.
- Capture: if fu_br_valid[f] and fu_br_bmm[f] has bit k set, slot k loads at the next edge.
  - mispred = taken != pred_taken.
  - Stored b_m = fu_br_b_m & ~(bit resolved this cycle).
- Output taken field = stored pred_taken; target_PC = stored target_PC. The branch stack then restores to recovery_PC when the prediction was taken, and to target_PC otherwise.
- Selection (combinational over stored slots only, no bypass of same-cycle inputs):
  - P = valid & mispred bits.
  - Choose a slot k in P with (b_m[k] & P) == 0; this is the unique oldest mispredict.
  - If P is empty, choose the lowest-index valid slot.
  - If no slot is valid, select nothing.
- Issue (at the edge):
  - branch_completing <= {bmm = onehot(k), bm_mispred = slot k mispred, target_PC, taken}.
  - Slot k is cleared.
  - If nothing is selected, branch_completing <= '0 (bmm = 0 means no resolution).
- Correct resolve of bit k: every stored slot and every same-cycle incoming result clears bit k of its b_m.
- Mispredict of bit k:
  - Every slot whose b_m has bit k is invalidated.
  - Every incoming result whose b_m has bit k is dropped.
  - Slots without bit k keep their b_m unchanged.
- Latency: FU result in cycle N -> stored at end of N -> selectable in N+1 -> on branch_completing in N+2 (minimum).
- Throughput: one resolution per cycle, never stalls FUs. Capacity equals the b-mask width, so full is impossible.
- Error conditions:
  - A capture into an already-valid slot is illegal; assertion fires, new data overwrites.
  - Two FUs with the same bmm in one cycle is illegal; assertion fires.
- Simultaneous events within one edge:
  - The issued slot is cleared.
  - A capture into a slot squashed by that cycle's mispredict is suppressed.
  - Captures into other slots proceed.
- Reset (asynchronous, active-low, allowed at any time): all slots invalid, branch_completing = '0, pending_mask = 0. Takes effect immediately, not at the next edge.

Decomposition:
- Shared package (sys_defs): BR_RESULT_PACKET {bmm, b_m, taken, pred_taken, target_PC}; reuse existing B_MASK, B_MASK_MASK, BRANCH_REG_PACKET, ADDR, `B_MASK_WIDTH.
- Sub-module brq_oldest_select: combinational. Inputs valid, mispred and b_m arrays; outputs one-hot grant and a mispred flag. Reusable by the LSQ for age selection.

Test Plan:
- Single correct branch: FU0 bmm=0001, b_m=0000, taken=pred=1, target 0x100 in cycle 0 -> cycle 2 branch_completing = {0001, 0, 0x100, 1}; cycle 3 bmm = 0.
- Two mispredicts in one cycle: FU0 bmm=0010, b_m=0001 (mispred); FU1 bmm=0001, b_m=0000 (mispred) -> bit0 issued first with bm_mispred=1; slot 1 squashed; bit1 never issued; pending_mask = 0.
- Correct then dependent: bit0 correct and bit1 (b_m=0001, correct) captured together -> issues 0001 then 0010; slot 1 b_m reads 0000 after the first issue.
- Mispredict with a same-cycle incoming younger result: slot 0 mispred pending; in the issue cycle FU1 sends bmm=0100, b_m=0001 -> dropped; pending_mask stays 0.
- Mispredict ordering over correct: slots 2 (correct) and 3 (mispred, b_m=0000) pending -> bit3 issued first, then bit2, since 2 is not younger than 3.
- Reset asserted mid-stream with three slots pending -> outputs zero immediately (async); after release, no resolution issues until new captures.
